// File: rtl/tt_um_axi8_lite_proc.sv
// Byte-wide AXI4-Lite-style slave: IN_REG (addr 0) and RES_REG = ~IN_REG (addr 1).
// Optional feature macro: AXI8_SLVERR_EN enables SLVERR responses.
module tt_um_axi8_lite_proc (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic       awvalid, arvalid, wvalid, rready, bready, addr, wstrb;
  logic       awready, wready, bvalid, arready, rvalid;
  logic       aw_hs, w_hs, ar_hs;
  logic [7:0] in_reg, res_reg, rdata;
  logic       res_valid, wr_addr;
  logic [1:0] resp;
  logic       unused_ok;

  assign awvalid   = ui_in[0];
  assign arvalid   = ui_in[1];
  assign wvalid    = ui_in[2];
  assign rready    = ui_in[3];
  assign bready    = ui_in[4];
  assign addr      = ui_in[5];
  assign wstrb     = ui_in[6];
  assign unused_ok = &{1'b0, ena, ui_in[7]};

  // ARREADY also drops on AWVALID so a simultaneous request resolves in favour of the write.
  assign awready = (w_state == W_IDLE) && (r_state == R_IDLE);
  assign arready = (w_state == W_IDLE) && (r_state == R_IDLE) && !awvalid;
  assign wready  = (w_state == W_DATA);
  assign bvalid  = (w_state == W_RESP);
  assign rvalid  = (r_state == R_DATA);

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign ar_hs = arvalid && arready;

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  always_comb begin
    w_next = w_state;
    r_next = r_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_next = W_DATA;
      W_DATA:  if (wvalid) w_next = W_RESP;
      W_RESP:  if (bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_DATA;
      R_DATA:  if (rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

`ifdef AXI8_SLVERR_EN
  logic [1:0] bresp, rresp;

  always_ff @(posedge clk) begin
    if (rst) begin
      in_reg    <= 8'h00;
      res_reg   <= 8'h00;
      res_valid <= 1'b0;
      wr_addr   <= 1'b0;
      rdata     <= 8'h00;
      bresp     <= 2'b00;
      rresp     <= 2'b00;
    end else begin
      if (aw_hs) wr_addr <= addr;
      if (w_hs) begin
        bresp <= wr_addr ? 2'b10 : 2'b00;
        if (!wr_addr && wstrb) begin
          in_reg    <= uio_in;
          res_reg   <= ~uio_in;
          res_valid <= 1'b1;
        end
      end
      if (ar_hs) begin
        if (addr && !res_valid) begin
          rdata <= 8'h00;
          rresp <= 2'b10;
        end else begin
          rdata <= addr ? res_reg : in_reg;
          rresp <= 2'b00;
        end
      end
    end
  end

  assign resp = bvalid ? bresp : (rvalid ? rresp : 2'b00);
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      in_reg    <= 8'h00;
      res_reg   <= 8'h00;
      res_valid <= 1'b0;
      wr_addr   <= 1'b0;
      rdata     <= 8'h00;
    end else begin
      if (aw_hs) wr_addr <= addr;
      if (w_hs && !wr_addr && wstrb) begin
        in_reg    <= uio_in;
        res_reg   <= ~uio_in;
        res_valid <= 1'b1;
      end
      if (ar_hs) rdata <= addr ? res_reg : in_reg;
    end
  end

  assign resp = 2'b00;
`endif

  assign uo_out  = {res_valid, resp, rvalid, arready, bvalid, wready, awready};
  assign uio_out = rvalid ? rdata : 8'h00;
  assign uio_oe  = rvalid ? 8'hFF : 8'h00;

endmodule

// File: tb/tb_tt_um_axi8_lite_proc.sv
// Directed self-checking bench for tt_um_axi8_lite_proc (honours AXI8_SLVERR_EN if defined).
module tb_tt_um_axi8_lite_proc;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int errors = 0;
  int checks = 0;
  logic rv = 1'b0;

  localparam logic [7:0] AWV = 8'h01, ARV = 8'h02, WV = 8'h04, RR = 8'h08, BR = 8'h10;
  localparam logic [7:0] A1 = 8'h20, ST = 8'h40;

`ifdef AXI8_SLVERR_EN
  localparam logic [1:0] ERR = 2'b10;
`else
  localparam logic [1:0] ERR = 2'b00;
`endif

  tt_um_axi8_lite_proc dut (
    .clk(clk), .rst(rst), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %02h, expected %02h", tag, actual, expected);
    end
  endtask

  // Drive inputs on the falling edge; outputs are checked 1ns later, well away from the rising edge.
  task automatic applyStimulus(input logic [7:0] ui, input logic [7:0] data);
    @(negedge clk);
    ui_in  = ui;
    uio_in = data;
    #1;
  endtask

  task automatic doWrite(input logic a, input logic [7:0] data, input logic strb, input logic [1:0] bresp);
    logic [7:0] ctl;
    ctl = (a ? A1 : 8'h00) | (strb ? ST : 8'h00);
    applyStimulus(AWV | ctl, 8'h00);
    checkOutput("aw_idle", uo_out, {rv, 7'h09} & 8'h81);
    applyStimulus(WV | ctl, data);
    checkOutput("w_data", uo_out, {rv, 7'h02});
    if (!a && strb) rv = 1'b1;
    applyStimulus(BR, 8'h00);
    checkOutput("b_resp", uo_out, {rv, bresp, 5'h04});
  endtask

  task automatic doRead(input logic a, input logic [7:0] expData, input logic [1:0] rresp);
    applyStimulus(ARV | (a ? A1 : 8'h00), 8'h00);
    checkOutput("ar_idle", uo_out, {rv, 7'h09});
    applyStimulus(RR, 8'h00);
    checkOutput("r_status", uo_out, {rv, rresp, 5'h10});
    checkOutput("r_data", uio_out, expData);
    checkOutput("r_oe", uio_oe, 8'hFF);
  endtask

  initial begin
    // Reset held for five cycles
    rst = 1'b1;
    repeat (5) applyStimulus(8'h00, 8'h00);
    checkOutput("rst_uo", uo_out, 8'h09);
    checkOutput("rst_oe", uio_oe, 8'h00);
    checkOutput("rst_out", uio_out, 8'h00);
    rst = 1'b0;
    applyStimulus(8'h00, 8'h00);
    checkOutput("idle_uo", uo_out, 8'h09);

    doWrite(1'b0, 8'h5A, 1'b1, 2'b00);
    doRead(1'b1, 8'hA5, 2'b00);
    doWrite(1'b0, 8'h3C, 1'b1, 2'b00);
    doRead(1'b0, 8'h3C, 2'b00);
    doWrite(1'b0, 8'hFF, 1'b0, 2'b00);
    doRead(1'b1, 8'hC3, 2'b00);
    doRead(1'b0, 8'h3C, 2'b00);
    applyStimulus(8'h00, 8'h00);
    checkOutput("idle_after_rd", uo_out, 8'h89);
    checkOutput("idle_oe", uio_oe, 8'h00);

    // Write response backpressure
    applyStimulus(AWV | ST, 8'h00);
    applyStimulus(WV | ST, 8'h96);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(8'h00, 8'h00);
      checkOutput("b_hold", uo_out, 8'h84);
    end
    applyStimulus(BR, 8'h00);
    checkOutput("b_release", uo_out, 8'h84);
    applyStimulus(8'h00, 8'h00);
    checkOutput("b_done", uo_out, 8'h89);

    // Read response backpressure
    applyStimulus(ARV | A1, 8'h00);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(8'h00, 8'h00);
      checkOutput("r_hold", uo_out, 8'h90);
      checkOutput("r_hold_data", uio_out, 8'h69);
    end
    applyStimulus(RR, 8'h00);
    checkOutput("r_release", uio_oe, 8'hFF);
    applyStimulus(8'h00, 8'h00);
    checkOutput("r_done", uo_out, 8'h89);
    checkOutput("r_done_oe", uio_oe, 8'h00);

    // Simultaneous AW and AR: write first, read waits until B is consumed
    applyStimulus(AWV | ARV | ST, 8'h00);
    checkOutput("both_valid", uo_out, 8'h81);
    applyStimulus(ARV | WV | ST, 8'h11);
    checkOutput("both_wdata", uo_out, 8'h82);
    applyStimulus(ARV, 8'h00);
    checkOutput("both_bwait", uo_out, 8'h84);
    applyStimulus(ARV | BR, 8'h00);
    checkOutput("both_bresp", uo_out, 8'h84);
    applyStimulus(ARV, 8'h00);
    checkOutput("both_ar", uo_out, 8'h89);
    applyStimulus(RR, 8'h00);
    checkOutput("both_rvalid", uo_out, 8'h90);
    checkOutput("both_rdata", uio_out, 8'h11);

    // Write to the read-only result register
    doWrite(1'b1, 8'h77, 1'b1, ERR);
    doRead(1'b1, 8'hEE, 2'b00);
    doRead(1'b0, 8'h11, 2'b00);

    // Reset in the middle of a write aborts it
    applyStimulus(AWV | ST, 8'h00);
    applyStimulus(8'h00, 8'h00);
    checkOutput("mid_wdata", uo_out, 8'h82);
    rst = 1'b1;
    applyStimulus(WV | ST, 8'hAB);
    rst = 1'b0;
    rv = 1'b0;
    applyStimulus(8'h00, 8'h00);
    checkOutput("mid_rst_uo", uo_out, 8'h09);
    doRead(1'b0, 8'h00, 2'b00);
    doRead(1'b1, 8'h00, ERR);

    applyStimulus(8'h00, 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
